// File: rtl/weight_loader.sv
// Weight loader: turns a load command plus a stream of weight rows into
// NoC flits that write consecutive register-file words of one DPE.
module weight_loader #(
    parameter int DATAW = 512,
    parameter int USERW = 75,
    parameter int DESTW = 4,
    parameter int IDW   = 2,
    parameter int DPES  = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [DESTW-1:0]       cmd_node,
    input  logic [5:0]             cmd_dpe,
    input  logic [8:0]             cmd_base,
    input  logic [8:0]             cmd_len,

    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATAW-1:0]       in_data,

    output logic                   axis_tx_tvalid,
    input  logic                   axis_tx_tready,
    output logic [DATAW+USERW-1:0] axis_tx_tdata,
    output logic [DESTW-1:0]       axis_tx_tdest,
    output logic [IDW-1:0]         axis_tx_tid,
    output logic                   axis_tx_tlast,

    output logic                   busy,
    output logic                   done
);

    // Handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both 1; a valid source holds its payload until that edge.

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             armed;
    logic [DESTW-1:0] node_q;
    logic [5:0]       dpe_q;
    logic [8:0]       base_q;
    logic [8:0]       len_q;
    logic [9:0]       words_in;
    logic [9:0]       words_total;

    logic cmd_hs;
    logic in_hs;
    logic tx_hs;
    logic final_hs;

    logic [8:0]       rf_addr;
    logic [DPES-1:0]  dpe_onehot;
    logic [USERW-1:0] header;
    logic             row_is_last;

    assign cmd_hs   = cmd_valid && cmd_ready;
    assign in_hs    = in_valid && in_ready;
    assign tx_hs    = axis_tx_tvalid && axis_tx_tready;
    assign final_hs = (state == STREAM) && tx_hs && axis_tx_tlast;

    assign words_total = {1'b0, len_q} + 10'd1;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_hs) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (final_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // armed keeps cmd_ready low while reset is held and until the first edge after release.
    always_comb begin
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = armed;
            end
            STREAM: begin
                busy     = 1'b1;
                in_ready = (words_in < words_total) && (!axis_tx_tvalid || axis_tx_tready);
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // ---------------- command latch and row counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            node_q   <= '0;
            dpe_q    <= '0;
            base_q   <= '0;
            len_q    <= '0;
            words_in <= '0;
        end else if (cmd_hs) begin
            node_q   <= cmd_node;
            dpe_q    <= cmd_dpe;
            base_q   <= cmd_base;
            len_q    <= cmd_len;
            words_in <= '0;
        end else if (in_hs) begin
            words_in <= words_in + 10'd1;
        end
    end

    // ---------------- header for the row being accepted ----------------
    // 9-bit add wraps 511 -> 0 on its own.
    assign rf_addr     = base_q + words_in[8:0];
    assign dpe_onehot  = {{(DPES-1){1'b0}}, 1'b1} << dpe_q;
    assign header      = {dpe_onehot, 2'b11, rf_addr};
    assign row_is_last = (words_in == {1'b0, len_q});

    // ---------------- output register ----------------
    // Loading while the current flit leaves gives one flit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axis_tx_tvalid <= 1'b0;
            axis_tx_tdata  <= '0;
            axis_tx_tdest  <= '0;
            axis_tx_tlast  <= 1'b0;
        end else if (in_hs) begin
            axis_tx_tvalid <= 1'b1;
            axis_tx_tdata  <= {header, in_data};
            axis_tx_tdest  <= node_q;
            axis_tx_tlast  <= row_is_last;
        end else if (tx_hs) begin
            axis_tx_tvalid <= 1'b0;
        end
    end

    assign axis_tx_tid = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= final_hs;
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: random rows and commands, a queue of expected
// flits built from the header rules, and a negedge monitor that checks them.
module tb_weight_loader;
  localparam int DATAW = 512;
  localparam int USERW = 75;
  localparam int DESTW = 4;
  localparam int IDW   = 2;
  localparam int DPES  = 64;
  localparam int TW    = DATAW + USERW;
  localparam int EW    = DESTW + 1 + TW;
  localparam int BUDGET = 3000;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [DESTW-1:0] cmd_node;
  logic [5:0]       cmd_dpe;
  logic [8:0]       cmd_base;
  logic [8:0]       cmd_len;
  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] in_data;
  logic             axis_tx_tvalid;
  logic             axis_tx_tready;
  logic [TW-1:0]    axis_tx_tdata;
  logic [DESTW-1:0] axis_tx_tdest;
  logic [IDW-1:0]   axis_tx_tid;
  logic             axis_tx_tlast;
  logic             busy;
  logic             done;

  weight_loader #(
    .DATAW(DATAW), .USERW(USERW), .DESTW(DESTW), .IDW(IDW), .DPES(DPES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_node(cmd_node),
    .cmd_dpe(cmd_dpe), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .axis_tx_tvalid(axis_tx_tvalid), .axis_tx_tready(axis_tx_tready),
    .axis_tx_tdata(axis_tx_tdata), .axis_tx_tdest(axis_tx_tdest),
    .axis_tx_tid(axis_tx_tid), .axis_tx_tlast(axis_tx_tlast),
    .busy(busy), .done(done)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            hs_cyc[$];
  int chk_cnt = 0;
  int pass_cnt = 0;
  int hs_total = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;
  bit abort = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    chk_cnt++;
    $display("FAIL %s: timed out after %0d cycles at %0t", name, BUDGET, $time);
  endtask

  function automatic logic [DATAW-1:0] rand_row();
    logic [DATAW-1:0] r;
    for (int k = 0; k < DATAW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Expected flit from the command fields: {tdest, tlast, header, payload}.
  function automatic logic [EW-1:0] model_flit(input int node, input int dpe, input int base,
                                               input int i, input int len, input logic [DATAW-1:0] p);
    logic [USERW-1:0] hdr;
    logic [DESTW-1:0] d;
    int rf;
    hdr = '0;
    rf = (base + i) % 512;
    hdr[8:0] = rf[8:0];
    hdr[10:9] = 2'b11;
    hdr[11 + dpe] = 1'b1;
    d = node[DESTW-1:0];
    return {d, (i == len), hdr, p};
  endfunction

  // ---------------- tready generator ----------------
  initial begin
    axis_tx_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      axis_tx_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- reference of "first edge after reset" ----------------
  bit armed_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed_m = 1'b0;
    else armed_m = 1'b1;
  end

  // ---------------- monitor ----------------
  bit busy_exp = 1'b0;
  bit done_exp = 1'b0;
  bit stall_prev = 1'b0;
  int rows_acc = 0;
  int cur_len = 0;
  logic [EW-1:0] held;
  logic [EW-1:0] act_flit;
  logic [EW-1:0] exp_flit;
  bit inr_exp;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      busy_exp = 1'b0;
      done_exp = 1'b0;
      stall_prev = 1'b0;
      rows_acc = 0;
    end else begin
      act_flit = {axis_tx_tdest, axis_tx_tlast, axis_tx_tdata};
      chk("busy", 32'(busy), 32'(busy_exp));
      chk("done", 32'(done), 32'(done_exp));
      chk("cmd_ready", 32'(cmd_ready), 32'(armed_m && !busy_exp));
      inr_exp = busy_exp && (rows_acc < cur_len + 1) && (!axis_tx_tvalid || axis_tx_tready);
      chk("in_ready", 32'(in_ready), 32'(inr_exp));
      if (stall_prev) begin
        chk_cnt++;
        if (axis_tx_tvalid === 1'b1 && act_flit === held) pass_cnt++;
        else $display("FAIL stall_hold: tvalid=%0b flit=%h held=%h", axis_tx_tvalid, act_flit, held);
      end
      if (axis_tx_tvalid && axis_tx_tready) begin
        hs_total++;
        hs_cyc.push_back(cyc);
        chk("tid", 32'(axis_tx_tid), 32'd0);
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL flit: got unexpected flit %h expected none", act_flit);
        end else begin
          exp_flit = exp_q.pop_front();
          chk_cnt++;
          if (act_flit === exp_flit) pass_cnt++;
          else $display("FAIL flit: got %h expected %h", act_flit, exp_flit);
        end
      end
      done_exp = axis_tx_tvalid && axis_tx_tready && axis_tx_tlast;
      if (done_exp) busy_exp = 1'b0;
      if (cmd_valid && cmd_ready) begin
        busy_exp = 1'b1;
        rows_acc = 0;
        cur_len = int'(cmd_len);
      end
      if (in_valid && in_ready) rows_acc++;
      stall_prev = axis_tx_tvalid && !axis_tx_tready;
      held = act_flit;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_cmd(input int node, input int dpe, input int base, input int len, input int gap_max);
    logic [DATAW-1:0] rows[$];
    int budget;
    bit ok;
    @(posedge clk);
    #1;
    cmd_node = DESTW'(node);
    cmd_dpe = 6'(dpe);
    cmd_base = 9'(base);
    cmd_len = 9'(len);
    cmd_valid = 1'b1;
    ok = 1'b0;
    budget = 0;
    while (!ok && budget < BUDGET) begin
      @(negedge clk);
      budget++;
      if (cmd_ready && rst_n) ok = 1'b1;
    end
    if (!ok) begin
      timeout("cmd_accept");
      cmd_valid = 1'b0;
    end else begin
      for (int i = 0; i <= len; i++) begin
        rows.push_back(rand_row());
        exp_q.push_back(model_flit(node, dpe, base, i, len, rows[i]));
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      // Fields change after acceptance; the DUT must keep the latched ones.
      cmd_node = DESTW'($urandom);
      cmd_dpe = 6'($urandom);
      cmd_base = 9'($urandom);
      cmd_len = 9'($urandom);
      for (int i = 0; i <= len && ok; i++) begin
        if (gap_max > 0) begin
          repeat ($urandom_range(0, gap_max)) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        in_data = rows[i];
        in_valid = 1'b1;
        ok = 1'b0;
        budget = 0;
        while (!ok && !abort && budget < BUDGET) begin
          @(negedge clk);
          budget++;
          if (!abort && in_ready) ok = 1'b1;
        end
        if (ok) begin
          @(posedge clk);
          #1;
        end else if (!abort) begin
          timeout("row_accept");
        end
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || busy) && budget < BUDGET) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= BUDGET) timeout("wait_idle");
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  int n0;
  int budget;

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_node = '0;
    cmd_dpe = '0;
    cmd_base = '0;
    cmd_len = '0;
    in_valid = 1'b0;
    in_data = '0;
    #12;
    chk("rst_tvalid", 32'(axis_tx_tvalid), 32'd0);
    chk("rst_tlast", 32'(axis_tx_tlast), 32'd0);
    chk("rst_tdata_zero", 32'(|axis_tx_tdata), 32'd0);
    chk("rst_tdest", 32'(axis_tx_tdest), 32'd0);
    chk("rst_tid", 32'(axis_tx_tid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic load: 4 rows, full throughput, back-to-back flits.
    n0 = hs_cyc.size();
    run_cmd(10, 3, 0, 3, 0);
    wait_idle();
    if (hs_cyc.size() >= n0 + 4) chk("back_to_back_span", 32'(hs_cyc[n0+3] - hs_cyc[n0]), 32'd3);
    else chk("back_to_back_count", 32'(hs_cyc.size() - n0), 32'd4);

    // Address wrap 510, 511, 0, 1.
    run_cmd(5, 7, 510, 3, 0);
    wait_idle();

    // Single flit to the top DPE.
    run_cmd(2, 63, 100, 0, 0);
    wait_idle();

    // Random backpressure over a 16-word stream.
    rand_ready = 1'b1;
    run_cmd(7, 20, 300, 15, 0);
    wait_idle();

    // Second command raised while the first is still streaming.
    fork
      run_cmd(1, 1, 50, 5, 1);
      begin
        budget = 0;
        while (!busy && budget < BUDGET) begin
          @(negedge clk);
          budget++;
        end
        if (budget >= BUDGET) timeout("wait_busy");
        run_cmd(9, 40, 505, 7, 1);
      end
    join
    wait_idle();

    // Random commands with gaps and backpressure.
    for (int k = 0; k < 6; k++) begin
      run_cmd($urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 511),
              $urandom_range(0, 12), 2);
      wait_idle();
    end

    // Reset after 2 of 8 flits, then a fresh command.
    rand_ready = 1'b0;
    n0 = hs_total;
    fork
      run_cmd(3, 5, 200, 7, 0);
      begin
        budget = 0;
        while (hs_total < n0 + 2 && budget < BUDGET) begin
          @(posedge clk);
          budget++;
        end
        if (budget >= BUDGET) timeout("wait_two_flits");
        #2;
        rst_n = 1'b0;
        abort = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_tvalid", 32'(axis_tx_tvalid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
      end
    join
    abort = 1'b0;
    chk("midrst_flits_before", 32'(hs_total - n0), 32'd2);
    run_cmd(4, 6, 42, 2, 0);
    wait_idle();

    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Hard stop so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got %0d/%0d", pass_cnt, chk_cnt);
    $fatal(1, "global timeout");
  end
endmodule
